// File: rtl/ram_copy_engine_pkg.sv
// Shared constants and state encoding for the CPU/RAM block family.
// Default address and data widths match the CPU/blram buses.
package ram_copy_engine_pkg;

    localparam int RCE_SIZE   = 14;
    localparam int RCE_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } rce_state_t;

endpackage

// File: rtl/ram_copy_engine.sv
// Word-by-word RAM copy engine with running checksum: 2 cycles/word, done 1 cycle after last write.
// No backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped.
module ram_copy_engine
    import ram_copy_engine_pkg::*;
#(
    parameter int SIZE   = RCE_SIZE,
    parameter int DATA_W = RCE_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   src_addr,
    input  logic [SIZE-1:0]   dst_addr,
    input  logic [SIZE-1:0]   len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              wrEn,
    output logic [SIZE-1:0]   addr_toRAM,
    output logic [DATA_W-1:0] data_toRAM,
    input  logic [DATA_W-1:0] data_fromRAM
);

    rce_state_t        state, state_nxt;
    logic [SIZE-1:0]   src_q, dst_q, len_q, idx_q, addr_q;
    logic [SIZE-1:0]   idx_inc;
    logic [DATA_W-1:0] sum_q;
    logic              accept;

    assign accept     = (state == ST_IDLE) && start;
    assign idx_inc    = idx_q + SIZE'(1);
    assign data_toRAM = data_fromRAM;
    assign checksum   = sum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            addr_q <= '0;
            sum_q  <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_toRAM;
            if (accept) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                len_q <= len;
                idx_q <= '0;
                sum_q <= '0;
            end else if (state == ST_WR) begin
                sum_q <= sum_q + data_fromRAM;
                idx_q <= idx_inc;
            end
        end
    end

    // Address is driven combinationally so reset drops wrEn and addr at once;
    // addr_q keeps the last presented address visible while idle.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        wrEn       = 1'b0;
        addr_toRAM = addr_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? ST_RD : ST_DONE;
                end
            end
            ST_RD: begin
                busy       = 1'b1;
                addr_toRAM = src_q + idx_q;
                state_nxt  = ST_WR;
            end
            ST_WR: begin
                busy       = 1'b1;
                wrEn       = 1'b1;
                addr_toRAM = dst_q + idx_q;
                state_nxt  = (idx_inc < len_q) ? ST_RD : ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Scoreboard bench for ram_copy_engine against a registered-read 1024-word RAM model.
module tb_ram_copy_engine;

    typedef struct packed {
        logic [13:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] src_addr, dst_addr, len;
    logic        busy, done, wrEn;
    logic [31:0] checksum, data_toRAM, data_fromRAM;
    logic [13:0] addr_toRAM;

    logic        start10;
    logic [9:0]  src10, dst10, len10, addr10;
    logic        busy10, done10, wr10;
    logic [31:0] cs10, dto10, dfrom10;

    logic        ld_en, ld_sel;
    logic [9:0]  ld_addr;
    logic [31:0] ld_dat;

    logic [31:0] mem   [1024];
    logic [31:0] mem10 [1024];

    wr_t         wq[$];
    logic [31:0] cq[$];
    wr_t         e;
    logic [31:0] ecs;
    int          pass_cnt = 0;
    int          tot_cnt  = 0;
    int          wr_seen  = 0;

    always #5 clk = ~clk;

    ram_copy_engine #(.SIZE(14), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .checksum(checksum), .wrEn(wrEn),
        .addr_toRAM(addr_toRAM), .data_toRAM(data_toRAM), .data_fromRAM(data_fromRAM)
    );

    ram_copy_engine #(.SIZE(10), .DATA_W(32)) u_dut10 (
        .clk(clk), .rst(rst), .start(start10), .src_addr(src10), .dst_addr(dst10),
        .len(len10), .busy(busy10), .done(done10), .checksum(cs10), .wrEn(wr10),
        .addr_toRAM(addr10), .data_toRAM(dto10), .data_fromRAM(dfrom10)
    );

    // blram-style memories: write on the edge, read data registered one cycle later
    always @(posedge clk) begin
        if (ld_en && !ld_sel) mem[ld_addr] <= ld_dat;
        else if (wrEn)        mem[addr_toRAM[9:0]] <= data_toRAM;
        data_fromRAM <= mem[addr_toRAM[9:0]];
    end

    always @(posedge clk) begin
        if (ld_en && ld_sel) mem10[ld_addr] <= ld_dat;
        else if (wr10)       mem10[addr10] <= dto10;
        dfrom10 <= mem10[addr10];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (wrEn) begin
                wr_seen++;
                if (wq.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                             addr_toRAM, data_toRAM);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addr", 32'(addr_toRAM), 32'(e.a));
                    chk("wr_data", data_toRAM, e.d);
                end
            end
            if (done) begin
                if (cq.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_done: checksum 0x%0h, no done expected", checksum);
                end else begin
                    ecs = cq.pop_front();
                    chk("done_checksum", checksum, ecs);
                end
            end
        end
    end

    task automatic load(input logic sel, input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_sel = sel; ld_addr = a; ld_dat = d; ld_en = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // inj=1: second start pulsed while busy; inj=2: start pulsed during the DONE cycle
    task automatic run_copy(input logic [13:0] s, input logic [13:0] d, input logic [13:0] l,
                            input int exp_edge, input int inj, input string nm);
        int got;
        got = -1;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 100 && got < 0; k++) begin
            @(negedge clk);
            if (inj == 1 && k == 1) begin
                start = 1'b1; src_addr = 14'd0; dst_addr = 14'd500; len = 14'd1;
            end else if (inj == 1 && k == 2) begin
                start = 1'b0;
            end
            if (done) begin
                got = k;
                if (inj == 2) begin
                    start = 1'b1; src_addr = 14'd0; dst_addr = 14'd500; len = 14'd1;
                end
            end
        end
        if (inj == 2) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk({nm, "_done_edge"}, 32'(got), 32'(exp_edge));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int got10;
        rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        start10 = 1'b0; src10 = '0; dst10 = '0; len10 = '0;
        ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_dat = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wren", 32'(wrEn), 32'd0);
        chk("rst_addr", 32'(addr_toRAM), 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // basic two-word copy with an ignored start while busy
        load(1'b0, 10'd100, 32'd6);
        load(1'b0, 10'd101, 32'd0);
        load(1'b0, 10'd500, 32'hDEAD_BEEF);
        load(1'b0, 10'd0,   32'h55);
        wq.push_back('{a: 14'd200, d: 32'd6});
        wq.push_back('{a: 14'd201, d: 32'd0});
        cq.push_back(32'd6);
        w0 = wr_seen;
        run_copy(14'd100, 14'd200, 14'd2, 4, 1, "basic");
        chk("basic_wr_cycles", 32'(wr_seen - w0), 32'd2);
        chk("basic_mem200", mem[200], 32'd6);
        chk("basic_mem201", mem[201], 32'd0);
        chk("busy_ign_mem500", mem[500], 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        chk("checksum_hold", checksum, 32'd6);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_addr_hold", 32'(addr_toRAM), 32'd201);

        // zero-length copy, start pulsed during DONE must be dropped
        cq.push_back(32'd0);
        w0 = wr_seen;
        run_copy(14'd7, 14'd9, 14'd0, 0, 2, "len0");
        repeat (4) @(negedge clk);
        chk("len0_wr_cycles", 32'(wr_seen - w0), 32'd0);
        chk("len0_checksum", checksum, 32'd0);
        chk("done_ign_busy", 32'(busy), 32'd0);
        chk("done_ign_mem500", mem[500], 32'hDEAD_BEEF);

        // overlapping forward copy smears the first word
        load(1'b0, 10'd10, 32'h11);
        load(1'b0, 10'd11, 32'h22);
        load(1'b0, 10'd12, 32'h33);
        wq.push_back('{a: 14'd11, d: 32'h11});
        wq.push_back('{a: 14'd12, d: 32'h11});
        wq.push_back('{a: 14'd13, d: 32'h11});
        cq.push_back(32'h33);
        run_copy(14'd10, 14'd11, 14'd3, 6, 0, "overlap");
        chk("overlap_mem11", mem[11], 32'h11);
        chk("overlap_mem12", mem[12], 32'h11);
        chk("overlap_mem13", mem[13], 32'h11);

        // reset during the second WR of a four-word copy
        load(1'b0, 10'd20, 32'd1);
        load(1'b0, 10'd21, 32'd2);
        load(1'b0, 10'd22, 32'd3);
        load(1'b0, 10'd23, 32'd4);
        load(1'b0, 10'd40, 32'hEE);
        load(1'b0, 10'd41, 32'hEE);
        load(1'b0, 10'd42, 32'hEE);
        wq.push_back('{a: 14'd40, d: 32'd1});
        @(negedge clk);
        src_addr = 14'd20; dst_addr = 14'd40; len = 14'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_wren", 32'(wrEn), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_addr", 32'(addr_toRAM), 32'd0);
        chk("abort_checksum", checksum, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_mem40", mem[40], 32'd1);
        chk("abort_mem41", mem[41], 32'hEE);
        chk("abort_mem42", mem[42], 32'hEE);
        @(posedge clk);
        #2 rst = 1'b1;
        wq.push_back('{a: 14'd60, d: 32'd3});
        wq.push_back('{a: 14'd61, d: 32'd4});
        cq.push_back(32'd7);
        run_copy(14'd22, 14'd60, 14'd2, 4, 0, "after_rst");

        // SIZE=10 instance: source address wraps from 1023 to 0
        load(1'b1, 10'd1023, 32'hA5A5);
        load(1'b1, 10'd0,    32'h5A5A);
        @(negedge clk);
        src10 = 10'd1023; dst10 = 10'd300; len10 = 10'd2; start10 = 1'b1;
        @(posedge clk);
        #1 start10 = 1'b0;
        got10 = -1;
        for (int k = 0; k < 100 && got10 < 0; k++) begin
            @(negedge clk);
            if (k == 0) chk("wrap_busy", 32'(busy10), 32'd1);
            if (done10) got10 = k;
        end
        chk("wrap_done_edge", 32'(got10), 32'd4);
        chk("wrap_checksum", cs10, 32'hFFFF);
        chk("wrap_mem300", mem10[300], 32'hA5A5);
        chk("wrap_mem301", mem10[301], 32'h5A5A);

        repeat (3) @(negedge clk);
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("cq_drained", 32'(cq.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
